// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - data memory with RV32I load/store front end and post-reset clear sequencer
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready    request handshake; req_ready is low while clearing
//   req_we                   0 = load, 1 = store
//   req_funct3               RV32I load/store funct3 (size and signedness)
//   req_addr                 byte address; word index = req_addr[31:2]
//   req_wdata                right-aligned store data
//   rsp_valid                registered response to the request accepted on the previous edge
//   rsp_rdata                extended load data; 0 for stores and faulted requests
//   rsp_err                  request faulted (illegal funct3, misaligned, out of range)

module dmem_lsu #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] clr_cnt;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          illegal;
    logic          misalign;
    logic          out_of_range;
    logic          err;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   ld_data;

    assign req_ready = (state == ST_RUN);
    assign accept    = req_valid & req_ready;
    assign idx       = req_addr[AW+1:2];
    assign rd_word   = mem[idx];

    always_comb begin
        is_byte      = (req_funct3[1:0] == 2'b00);
        is_half      = (req_funct3[1:0] == 2'b01);
        is_word      = (req_funct3[1:0] == 2'b10);
        // 011/111 have no size, 110 would be an unsigned word; stores have no unsigned form.
        illegal      = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                       (req_we && req_funct3[2]);
        misalign     = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
        out_of_range = |req_addr[31:AW+2];
        err          = illegal || misalign || out_of_range;

        // Replicate store data across lanes so each enabled lane picks its own slice.
        be = 4'b0000;
        wd = req_wdata;
        if (is_byte) begin
            be = 4'b0001 << req_addr[1:0];
            wd = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            be = req_addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{req_wdata[15:0]}};
        end else if (is_word) begin
            be = 4'b1111;
        end

        // funct3[2] set means zero-extend.
        rd_shift = rd_word >> {req_addr[1:0], 3'b000};
        if (is_byte) begin
            ld_data = {{24{~req_funct3[2] & rd_shift[7]}}, rd_shift[7:0]};
        end else if (is_half) begin
            ld_data = {{16{~req_funct3[2] & rd_shift[15]}}, rd_shift[15:0]};
        end else begin
            ld_data = rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    state <= ST_RUN;
                end
            end
            rsp_valid <= accept;
            rsp_err   <= accept && err;
            rsp_rdata <= (accept && !req_we && !err) ? ld_data : 32'h0;
        end
    end

    // Storage has no reset; the clear sequencer zeroes it one word per cycle instead.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (accept && req_we && !err) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[idx][8*k +: 8] <= wd[8*k +: 8];
                end
            end
        end
    end

endmodule
